// File: rtl/cpu_run_ctl_if.sv
// Control strobes between board support logic and the CPU run controller.
// The controller takes the slave modport; the support side or a bench takes master.
interface cpu_run_ctl_if;
    logic       boot;
    logic       halt;
    logic       step;
    logic       interrupt;
    logic       int_taken;
    logic       cpu_reset;
    logic       boot_load;
    logic       run;
    logic       int_pend;
    logic       int_ack;
    logic [2:0] state;

    modport master (
        output boot, halt, step, interrupt, int_taken,
        input  cpu_reset, boot_load, run, int_pend, int_ack, state
    );

    modport slave (
        input  boot, halt, step, interrupt, int_taken,
        output cpu_reset, boot_load, run, int_pend, int_ack, state
    );
endinterface

// File: rtl/cpu_run_ctl.sv
// CPU run controller: sequences reset hold, boot vector load, run/halt/single-step
// and an interrupt request/acknowledge handshake toward the CPU core.
module cpu_run_ctl #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned BOOT_CYCLES  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    cpu_run_ctl_if.slave  bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        BOOT     = 3'd2,
        RUN      = 3'd3,
        HALTED   = 3'd4,
        STEP     = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             boot_q;
    logic             boot_rise;
    logic             restart;
    logic             accept;
    logic             pend_q;
    logic             pend_n;
    logic             ack_q;
    logic             ack_n;
    logic             armed_q;
    logic             armed_n;
    logic             cpu_reset_q;
    logic             boot_load_q;
    logic             run_q;

    assign boot_rise = bus.boot & ~boot_q;
    // Saturating increment so a misconfigured length can never wrap.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, counter and interrupt handshake decode.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        restart = 1'b0;
        accept  = 1'b0;
        pend_n  = pend_q;
        ack_n   = 1'b0;
        armed_n = armed_q;

        case (state_q)
            RST_HOLD: begin
                if (cnt_q == RST_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            IDLE: begin
                if (boot_rise) begin
                    state_n = BOOT;
                    cnt_n   = '0;
                end
            end
            BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_n = bus.halt ? HALTED : RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    state_n = HALTED;
                end
            end
            HALTED: begin
                // Holding halt blocks a step; a step is taken on the cycle halt drops.
                if (!bus.halt) begin
                    state_n = bus.step ? STEP : RUN;
                end
            end
            STEP: begin
                state_n = HALTED;
            end
            default: begin
                state_n = RST_HOLD;
                cnt_n   = '0;
            end
        endcase

        restart = boot_rise && (state_q != RST_HOLD) && (state_q != IDLE);
        if (restart) begin
            state_n = RST_HOLD;
            cnt_n   = '0;
        end

        accept = pend_q && bus.int_taken && !restart;
        if (restart) begin
            pend_n = 1'b0;
        end else if (accept) begin
            pend_n = 1'b0;
            ack_n  = 1'b1;
        end else if (!pend_q && armed_q && bus.interrupt &&
                     ((state_q == RUN) || (state_q == STEP))) begin
            pend_n = 1'b1;
        end

        // A level held past its acknowledge must drop before it can request again.
        if (!bus.interrupt) begin
            armed_n = 1'b1;
        end else if (accept) begin
            armed_n = 1'b0;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            boot_q      <= 1'b0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            armed_q     <= 1'b1;
            cpu_reset_q <= 1'b1;
            boot_load_q <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            boot_q      <= bus.boot;
            pend_q      <= pend_n;
            ack_q       <= ack_n;
            armed_q     <= armed_n;
            cpu_reset_q <= (state_n == RST_HOLD);
            boot_load_q <= (state_n == BOOT);
            run_q       <= (state_n == RUN) || (state_n == STEP);
        end
    end

    assign bus.cpu_reset = cpu_reset_q;
    assign bus.boot_load = boot_load_q;
    assign bus.run       = run_q;
    assign bus.int_pend  = pend_q;
    assign bus.int_ack   = ack_q;
    assign bus.state     = 3'(state_q);

endmodule
